sbox_word_seq: RTL and testbench

Byte-serial substitution sequencer that pushes a multi-byte word through the single shared, registered 256-entry S-box LUT (`S_BOX_LUT_2`: `sel[7:0]`, `en`, `CLK`, `data[7:0]`, 1-cycle read latency, no reset) one byte per cycle, then reassembles the substituted word. It sits between the round/key-schedule control and the LUT, giving an upstream producer a valid/ready word interface and hiding the LUT's latency and byte sequencing.

---
 rtl/sbox_seq_pkg.sv | 20 ++
 rtl/sbox_word_seq.sv | 141 ++++++++++++++
 tb/tb_sbox_word_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_seq_pkg.sv
// sbox_seq_pkg
//   Shared definitions for the byte-serial S-box word sequencer.
//   - seq_state_t : sequencer FSM states (IDLE, ISSUE, DRAIN, DONE)
//   - BYTE_W      : width of one substituted byte
//   - LUT_DEPTH   : number of entries in the shared S-box LUT
//   - SEL_W       : width of the LUT select bus derived from LUT_DEPTH
package sbox_seq_pkg;

    localparam int BYTE_W    = 8;
    localparam int LUT_DEPTH = 256;
    localparam int SEL_W     = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/sbox_word_seq.sv
// sbox_word_seq
//   Pushes a multi-byte word through the shared, registered S-box LUT one
//   byte per cycle and reassembles the substituted word. The LUT itself lives
//   outside this block so that other requesters can share it later.
//
//   Parameter
//     WORD_BYTES : bytes per word (>= 2)
//   Ports
//     CLK, RST             : clock, synchronous active-high reset
//     in_valid / in_ready  : upstream word handshake
//     in_word              : word to substitute, byte k = in_word[8k+7:8k]
//     in_rot               : rotate-left-by-one-byte request (RotWord)
//     out_valid / out_ready: downstream word handshake
//     out_word             : substituted word, stable while out_valid
//     busy                 : high whenever the sequencer is not IDLE
//     lut_sel, lut_en      : drive the LUT select and enable
//     lut_data             : LUT registered output (1-cycle read latency)
//
//   Build option
//     SBOX_SEQ_ROTWORD_EN : when defined, in_rot=1 at accept rotates the
//                           latched word left by 8 bits before substitution.
//                           When undefined, in_rot is ignored.
module sbox_word_seq
    import sbox_seq_pkg::*;
#(
    parameter int WORD_BYTES = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BYTE_W*WORD_BYTES-1:0] in_word,
    input  logic                         in_rot,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BYTE_W*WORD_BYTES-1:0] out_word,
    output logic                         busy,
    output logic [SEL_W-1:0]             lut_sel,
    output logic                         lut_en,
    input  logic [BYTE_W-1:0]            lut_data
);

    localparam int              CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

    seq_state_t                         state;
    seq_state_t                         state_next;
    logic [CNT_W-1:0]                   cnt;
    logic [WORD_BYTES-1:0][BYTE_W-1:0]  word_q;
    logic [WORD_BYTES-1:0][BYTE_W-1:0]  result_q;
    logic [WORD_BYTES-1:0][BYTE_W-1:0]  accept_word;

    // Word presented for latching at accept time. With RotWord enabled the
    // top byte moves to byte 0, so it is the first one sent to the LUT.
`ifdef SBOX_SEQ_ROTWORD_EN
    assign accept_word = in_rot
        ? {in_word[BYTE_W*WORD_BYTES-BYTE_W-1:0],
           in_word[BYTE_W*WORD_BYTES-1:BYTE_W*WORD_BYTES-BYTE_W]}
        : in_word;
`else
    logic unused_rot;
    assign unused_rot  = in_rot;
    assign accept_word = in_word;
`endif

    // State, byte counter, latched word and result assembly. The LUT answers
    // one cycle after a byte is issued, so while issuing byte cnt we capture
    // the answer for byte cnt-1; the last answer arrives during DRAIN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            word_q   <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_q <= accept_word;
                        cnt    <= '0;
                    end
                end
                ISSUE: begin
                    if (cnt != '0) begin
                        result_q[cnt - CNT_W'(1)] <= lut_data;
                    end
                    if (cnt != LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    result_q[WORD_BYTES-1] <= lut_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and per-state outputs; everything defaults to its idle value
    // so the LUT is only enabled and selected while issuing.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        lut_en     = 1'b0;
        lut_sel    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                lut_en  = 1'b1;
                lut_sel = word_q[cnt];
                if (cnt == LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign out_word = result_q;

endmodule

// File: tb/tb_sbox_word_seq.sv
// tb_sbox_word_seq
//   Directed bench for sbox_word_seq (WORD_BYTES=4). A behavioural registered
//   LUT stands in for S_BOX_LUT_2; it holds the table entries the vectors use
//   (00->6C, 01->DA, 02->C3, 03->E9, 10->BF, FF->1D) and a filler elsewhere.
//   Honours SBOX_SEQ_ROTWORD_EN for the RotWord expectations.
module tb_sbox_word_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_rot;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        busy;
    logic [7:0]  lut_sel;
    logic        lut_en;
    logic [7:0]  lut_data;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    sbox_word_seq #(.WORD_BYTES(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .in_rot   (in_rot),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .busy     (busy),
        .lut_sel  (lut_sel),
        .lut_en   (lut_en),
        .lut_data (lut_data)
    );

    function automatic logic [7:0] lut_value(input logic [7:0] sel);
        case (sel)
            8'h00:   lut_value = 8'h6C;
            8'h01:   lut_value = 8'hDA;
            8'h02:   lut_value = 8'hC3;
            8'h03:   lut_value = 8'hE9;
            8'h10:   lut_value = 8'hBF;
            8'hFF:   lut_value = 8'h1D;
            default: lut_value = sel ^ 8'h5A;
        endcase
    endfunction

    // Registered, unreset LUT model with one-cycle read latency.
    always @(posedge CLK) begin
        if (lut_en) lut_data <= lut_value(lut_sel);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents a word for one cycle; the sequencer must be IDLE.
    task automatic applyStimulus(input logic [31:0] w, input logic rot);
        in_word  = w;
        in_rot   = rot;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_rot   = 1'b0;
    endtask

    // Waits (bounded) for out_valid and compares the result word.
    task automatic wait_result(input string name, input logic [31:0] exp);
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (!out_valid) begin
            $display("[TB] FAIL %s: timeout waiting for out_valid", name);
        end else if (out_word !== exp) begin
            $display("[TB] FAIL %s: out_word=%h expected %h", name, out_word, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, lut_en} !== 4'b1000) begin
            $display("[TB] FAIL reset_flags: ready/valid/busy/en=%b expected 1000",
                     {in_ready, out_valid, busy, lut_en});
        end else passed++;
        total++;
        if (out_word !== 32'h0 || lut_sel !== 8'h00) begin
            $display("[TB] FAIL reset_data: out_word=%h lut_sel=%h expected 0/0", out_word, lut_sel);
        end else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] exp_sel;
        out_ready = 1'b0;
        applyStimulus(32'h03020100, 1'b0);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            $display("[TB] FAIL basic_busy: in_ready=%b busy=%b expected 0/1", in_ready, busy);
        end else passed++;
        for (int k = 0; k < 4; k++) begin
            exp_sel = 8'(k);
            total++;
            if (lut_en !== 1'b1 || lut_sel !== exp_sel) begin
                $display("[TB] FAIL basic_sel%0d: en=%b sel=%h expected 1/%h", k, lut_en, lut_sel, exp_sel);
            end else passed++;
            tick();
        end
        total++;
        if (lut_en !== 1'b0 || lut_sel !== 8'h00 || out_valid !== 1'b0) begin
            $display("[TB] FAIL basic_drain: en=%b sel=%h valid=%b expected 0/00/0", lut_en, lut_sel, out_valid);
        end else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_word !== 32'hE9C3DA6C) begin
            $display("[TB] FAIL basic_result: valid=%b out_word=%h expected 1/e9c3da6c", out_valid, out_word);
        end else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("[TB] FAIL basic_release: valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int  n = 0;
        bit  got = 0;
        bit  prev_ov = 0;
        bit  res_seen = 0;
        bit  acc;
        out_ready = 1'b1;
        applyStimulus(32'hFFFFFFFF, 1'b0);
        in_valid = 1'b1;
        while (!got && n < 20) begin
            if (out_valid && !res_seen) begin
                res_seen = 1;
                total++;
                if (out_word !== 32'h1D1D1D1D) begin
                    $display("[TB] FAIL b2b_result: out_word=%h expected 1d1d1d1d", out_word);
                end else passed++;
            end
            if (prev_ov) begin
                total++;
                if (in_ready !== 1'b1) begin
                    $display("[TB] FAIL b2b_done_to_idle: in_ready=%b expected 1", in_ready);
                end else passed++;
            end
            prev_ov = out_valid;
            acc = in_ready;
            tick();
            n++;
            if (acc) got = 1;
        end
        in_valid = 1'b0;
        total++;
        if (n !== 7) begin
            $display("[TB] FAIL b2b_spacing: accept spacing=%0d expected 7", n);
        end else passed++;
        wait_result("b2b_second", 32'h1D1D1D1D);
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp = 32'h1DBFBFE9;
        int bad = 0;
        out_ready = 1'b0;
        applyStimulus(32'hFF101003, 1'b0);
        wait_result("bp_result", exp);
        for (int i = 0; i < 10; i++) begin
            in_word  = 32'h00000000;
            in_valid = (i == 5);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== exp) bad++;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (bad != 0 || out_valid !== 1'b1 || out_word !== exp) begin
            $display("[TB] FAIL bp_hold: bad_cycles=%0d valid=%b out_word=%h expected 0/1/%h",
                     bad, out_valid, out_word, exp);
        end else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("[TB] FAIL bp_release: valid=%b in_ready=%b busy=%b expected 0/1/0",
                     out_valid, in_ready, busy);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        applyStimulus(32'h03020100, 1'b0);
        tick();
        tick();
        total++;
        if (lut_sel !== 8'h02) begin
            $display("[TB] FAIL rstmid_cnt2: lut_sel=%h expected 02", lut_sel);
        end else passed++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, lut_en} !== 4'b1000 || out_word !== 32'h0) begin
            $display("[TB] FAIL rstmid_idle: ready/valid/busy/en=%b out_word=%h expected 1000/0",
                     {in_ready, out_valid, busy, lut_en}, out_word);
        end else passed++;
        applyStimulus(32'h10101010, 1'b0);
        wait_result("rstmid_next", 32'hBFBFBFBF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_rotword();
        logic [31:0] exp_sels;
        logic [31:0] exp_word;
        logic [7:0]  exp_sel;
`ifdef SBOX_SEQ_ROTWORD_EN
        exp_sels = 32'h02010003;
        exp_word = 32'hC3DA6CE9;
`else
        exp_sels = 32'h03020100;
        exp_word = 32'hE9C3DA6C;
`endif
        out_ready = 1'b0;
        applyStimulus(32'h03020100, 1'b1);
        for (int k = 0; k < 4; k++) begin
            exp_sel = exp_sels[8*k +: 8];
            total++;
            if (lut_sel !== exp_sel) begin
                $display("[TB] FAIL rot_sel%0d: lut_sel=%h expected %h", k, lut_sel, exp_sel);
            end else passed++;
            tick();
        end
        wait_result("rot_result", exp_word);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_word   = 32'h0;
        in_rot    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_rotword();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
